// File: rtl/ram_reset_seq_pkg.sv
// Shared types and helpers for the memory-subsystem reset sequencer.
package ram_reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_WAIT_CALIB,
        ST_RELEASE,
        ST_RUN
    } state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = 1; v < value; v = v << 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/ram_reset_seq_reset_sync_bit.sv
// Single-bit multi-flop synchroniser with synchronous reset.
module reset_sync_bit
    import ram_reset_seq_pkg::*;
#(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk_ui,
    input  logic reset_ui,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk_ui) begin
        if (reset_ui) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/ram_reset_seq.sv
// Reset sequencer: merges memory reset, soft reset and calibration loss
// into staggered per-channel active-low resets in the clk_ui domain.
module ram_reset_seq
    import ram_reset_seq_pkg::*;
#(
    parameter int unsigned CHANNELS         = 4,
    parameter int unsigned STRETCH          = 16,
    parameter int unsigned STAGGER          = 8,
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned CALIB_LOSS_RESET = 1
) (
    input  logic                clk_ui,
    input  logic                reset_ui,
    input  logic                memory_resetn,
    input  logic                calib_done,
    input  logic                soft_reset,
    output logic [CHANNELS-1:0] aresetn_out,
    output logic                reset_active,
    output logic                seq_done,
    output logic [7:0]          reset_count
);

    localparam int unsigned CW = cnt_width(STRETCH);
    localparam int unsigned SW = cnt_width(STAGGER);

    localparam logic [CHANNELS-1:0] ALL_ONES = '1;
    // Pattern present just before the final channel is released.
    localparam logic [CHANNELS-1:0] LAST_PRE = ALL_ONES >> 1;

    logic          mr_s;
    logic          cal_s;
    logic          cause;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] scnt;

    reset_sync_bit #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_mr (
        .clk_ui   (clk_ui),
        .reset_ui (reset_ui),
        .d        (memory_resetn),
        .q        (mr_s)
    );

    reset_sync_bit #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_cal (
        .clk_ui   (clk_ui),
        .reset_ui (reset_ui),
        .d        (calib_done),
        .q        (cal_s)
    );

    // Combine every reset cause; calibration loss only counts while running.
    always_comb begin
        cause = ~mr_s | soft_reset;
        if ((CALIB_LOSS_RESET != 0) && (state == ST_RUN) && !cal_s) begin
            cause = 1'b1;
        end
    end

    // Sequencer FSM with registered outputs and saturating event counter.
    // Released channels always form a contiguous run from bit 0, so the next
    // channel is released by shifting in a one instead of tracking an index.
    always_ff @(posedge clk_ui) begin
        if (reset_ui) begin
            state        <= ST_HOLD;
            cnt          <= '0;
            scnt         <= '0;
            aresetn_out  <= '0;
            reset_active <= 1'b1;
            seq_done     <= 1'b0;
            reset_count  <= '0;
        end else if (cause) begin
            state        <= ST_HOLD;
            cnt          <= '0;
            scnt         <= '0;
            aresetn_out  <= '0;
            reset_active <= 1'b1;
            seq_done     <= 1'b0;
            if ((state != ST_HOLD) && (reset_count != 8'hFF)) begin
                reset_count <= reset_count + 8'd1;
            end
        end else begin
            case (state)
                ST_HOLD: begin
                    if (cnt == CW'(STRETCH - 1)) begin
                        state <= ST_WAIT_CALIB;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_CALIB: begin
                    if (cal_s) begin
                        aresetn_out <= CHANNELS'(1);
                        scnt        <= '0;
                        if (CHANNELS == 1) begin
                            state        <= ST_RUN;
                            seq_done     <= 1'b1;
                            reset_active <= 1'b0;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (scnt == SW'(STAGGER - 1)) begin
                        scnt        <= '0;
                        aresetn_out <= (aresetn_out << 1) | CHANNELS'(1);
                        if (aresetn_out == LAST_PRE) begin
                            state        <= ST_RUN;
                            seq_done     <= 1'b1;
                            reset_active <= 1'b0;
                        end
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_HOLD;
                end
            endcase
        end
    end

endmodule
